// File: rtl/cnn_pixel_frame_receiver.sv
// Receives the pixel byte stream for one frame, packs four pixels per word
// into the CNN input buffer, and hands the finished frame over with a
// ready/ack handshake. Protocol violations collect in sticky error bits.
//
// Handshake: frame_ready is a level that rises the cycle after
// frame_complete and stays high until the cycle after frame_ack; frame_ack
// is ignored while frame_ready is low. The pixel side has no backpressure:
// every pixel_valid pulse is either accepted or dropped and flagged.
module cnn_pixel_frame_receiver #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H/4)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [7:0]               pixel_data,
  input  logic                     frame_complete,
  input  logic                     frame_ack,
  input  logic                     err_clear,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [31:0]              buf_wdata,
  output logic                     frame_ready,
  output logic [31:0]              frame_len,
  output logic                     busy,
  output logic                     line_done,
  output logic [$clog2(IMG_H)-1:0] row_idx,
  output logic [31:0]              frame_count,
  output logic [3:0]               err_flags,
  // Debug view of the state register: 0 = IDLE, 1 = RECV, 2 = DONE
  output logic [1:0]               dbg_state
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_d;
  logic [31:0]       pack_q, pack_d;
  logic              we_d, line_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, len_d, count_d;
  logic [3:0]        ev;
  logic              start_ok;

  assign dbg_state = state_q;

  // Next state and datapath: start is applied first, then the pixel, then
  // frame_complete, so coincident pulses compose in that order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_idx;
    pack_d  = pack_q;
    we_d    = 1'b0;
    addr_d  = buf_addr;
    wdata_d = buf_wdata;
    line_d  = 1'b0;
    len_d   = frame_len;
    count_d = frame_count;
    ev      = 4'b0000;

    start_ok = frame_start &&
               ((state_q == IDLE) || (state_q == RECV) ||
                ((state_q == DONE) && frame_ack));

    // A start while a frame is open or awaiting ack is a restart error
    if (frame_start && ((state_q == RECV) || ((state_q == DONE) && !frame_ack))) begin
      ev[3] = 1'b1;
    end

    if (start_ok) begin
      state_d = RECV;
      cnt_d   = '0;
      col_d   = '0;
      row_d   = '0;
      pack_d  = '0;
    end else if ((state_q == DONE) && frame_ack) begin
      state_d = IDLE;
    end

    if (pixel_valid) begin
      if (state_d != RECV) begin
        ev[0] = 1'b1;
      end else if (cnt_d == CNT_W'(TOTAL)) begin
        ev[1] = 1'b1;
      end else begin
        pack_d[8*cnt_d[1:0] +: 8] = pixel_data;
        if (cnt_d[1:0] == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = cnt_d[ADDR_W+1:2];
          wdata_d = pack_d;
          pack_d  = '0;
        end
        cnt_d = cnt_d + 1'b1;
        if (col_d == COL_W'(IMG_W - 1)) begin
          col_d  = '0;
          line_d = 1'b1;
          row_d  = (row_d == ROW_W'(IMG_H - 1)) ? '0 : row_d + 1'b1;
        end else begin
          col_d = col_d + 1'b1;
        end
      end
    end

    if (frame_complete && (state_d == RECV)) begin
      // Partial word goes out with its unused lanes already zero
      if (cnt_d[1:0] != 2'd0) begin
        we_d    = 1'b1;
        addr_d  = cnt_d[ADDR_W+1:2];
        wdata_d = pack_d;
        pack_d  = '0;
      end
      len_d   = 32'(cnt_d);
      ev[2]   = (cnt_d < CNT_W'(TOTAL));
      state_d = DONE;
      count_d = frame_count + 32'd1;
    end
  end

  // Register state, counters and every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      pack_q      <= '0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      row_idx     <= '0;
      frame_count <= '0;
      err_flags   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      pack_q      <= pack_d;
      buf_we      <= we_d;
      buf_addr    <= addr_d;
      buf_wdata   <= wdata_d;
      frame_ready <= (state_d == DONE);
      frame_len   <= len_d;
      busy        <= (state_d == RECV);
      line_done   <= line_d;
      row_idx     <= row_d;
      frame_count <= count_d;
      err_flags   <= (err_clear ? 4'b0000 : err_flags) | ev;
    end
  end

endmodule

// File: tb/tb_cnn_pixel_frame_receiver.sv
// Bench for cnn_pixel_frame_receiver with an 8x2 frame: directed scenarios
// followed by random pulse traffic, all checked against a frame-level model.
module tb_cnn_pixel_frame_receiver;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 2;
  localparam int TOTAL  = IMG_W * IMG_H;
  localparam int ADDR_W = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              pixel_valid = 1'b0;
  logic [7:0]        pixel_data = 8'h00;
  logic              frame_complete = 1'b0;
  logic              frame_ack = 1'b0;
  logic              err_clear = 1'b0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_wdata;
  logic              frame_ready;
  logic [31:0]       frame_len;
  logic              busy;
  logic              line_done;
  logic [0:0]        row_idx;
  logic [31:0]       frame_count;
  logic [3:0]        err_flags;
  logic [1:0]        dbg_state;

  cnn_pixel_frame_receiver #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .frame_complete(frame_complete), .frame_ack(frame_ack),
    .err_clear(err_clear), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .frame_ready(frame_ready), .frame_len(frame_len),
    .busy(busy), .line_done(line_done), .row_idx(row_idx),
    .frame_count(frame_count), .err_flags(err_flags), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int writes_seen = 0;
  int lines_seen = 0;
  logic [31:0] dut_mem [4];

  // Reference model: the frame is the list of accepted pixels
  logic [7:0]        m_pix[$];
  logic [1:0]        m_state;
  logic [ADDR_W+31:0] exp_q[$];
  logic              e_we, e_line, e_busy, e_ready;
  logic [0:0]        e_row;
  logic [31:0]       e_len, e_count;
  logic [3:0]        e_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int widx);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (widx*4 + k < m_pix.size()) w[8*k +: 8] = m_pix[widx*4 + k];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_pix.delete();
    exp_q.delete();
    m_state = S_IDLE;
    e_we = 0; e_line = 0; e_busy = 0; e_ready = 0;
    e_row = 0; e_len = 0; e_count = 0; e_err = 0;
  endtask

  task automatic model_step(input logic fs, pv, input logic [7:0] pd,
                            input logic fc, ack, ec);
    logic [1:0] st0;
    logic [3:0] ev;
    int n;
    st0 = m_state;
    ev = 4'b0;
    e_we = 0;
    e_line = 0;
    if (fs) begin
      if (st0 == S_DONE && !ack) ev[3] = 1'b1;
      else begin
        if (st0 == S_RECV) ev[3] = 1'b1;
        m_state = S_RECV;
        m_pix.delete();
      end
    end else if (ack && st0 == S_DONE) begin
      m_state = S_IDLE;
    end
    if (pv) begin
      if (m_state != S_RECV) ev[0] = 1'b1;
      else if (m_pix.size() == TOTAL) ev[1] = 1'b1;
      else begin
        m_pix.push_back(pd);
        n = m_pix.size();
        if (n % IMG_W == 0) e_line = 1'b1;
        if (n % 4 == 0) begin
          e_we = 1'b1;
          exp_q.push_back({ADDR_W'(n/4 - 1), word_at(n/4 - 1)});
        end
      end
    end
    if (fc && m_state == S_RECV) begin
      n = m_pix.size();
      if (n % 4 != 0) begin
        e_we = 1'b1;
        exp_q.push_back({ADDR_W'(n/4), word_at(n/4)});
      end
      e_len = n;
      if (n < TOTAL) ev[2] = 1'b1;
      m_state = S_DONE;
      e_count = e_count + 1;
    end
    e_err   = (ec ? 4'b0 : e_err) | ev;
    e_busy  = (m_state == S_RECV);
    e_ready = (m_state == S_DONE);
    e_row   = 1'((m_pix.size() / IMG_W) % IMG_H);
  endtask

  task automatic compare_outputs();
    logic [ADDR_W+31:0] w;
    check("buf_we", buf_we, e_we);
    if (buf_we) begin
      writes_seen++;
      dut_mem[buf_addr] = buf_wdata;
    end
    if (e_we && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("buf_addr", buf_addr, w[ADDR_W+31:32]);
      check("buf_wdata", buf_wdata, w[31:0]);
    end
    if (line_done) lines_seen++;
    check("line_done", line_done, e_line);
    check("busy", busy, e_busy);
    check("frame_ready", frame_ready, e_ready);
    check("row_idx", row_idx, e_row);
    check("frame_count", frame_count, e_count);
    check("err_flags", err_flags, e_err);
    check("state", dbg_state, m_state);
    if (e_ready) check("frame_len", frame_len, e_len);
  endtask

  // Driver: one clock cycle of input pulses, model update, output check
  task automatic cycle(input logic fs, pv, input logic [7:0] pd,
                       input logic fc, ack, ec);
    @(negedge clk);
    frame_start = fs; pixel_valid = pv; pixel_data = pd;
    frame_complete = fc; frame_ack = ack; err_clear = ec;
    model_step(fs, pv, pd, fc, ack, ec);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic pix(input logic [7:0] d);
    cycle(0, 1, d, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_start = 0; pixel_valid = 0; frame_complete = 0;
    frame_ack = 0; err_clear = 0;
    #1;
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_flags", err_flags, 0);
    check("rst_state", dbg_state, S_IDLE);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Full frame 0x00..0x0F
    writes_seen = 0; lines_seen = 0;
    cycle(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) pix(8'(i));
    cycle(0, 0, 8'h00, 1, 0, 0);
    check("full_writes", writes_seen, 4);
    check("full_addr0", dut_mem[0], 32'h03020100);
    check("full_addr3", dut_mem[3], 32'h0F0E0D0C);
    check("full_lines", lines_seen, 2);
    check("full_len", frame_len, 16);
    check("full_count", frame_count, 1);
    check("full_err", err_flags, 4'h0);
    cycle(0, 0, 8'h00, 0, 1, 0);
    idle();

    // Short frame 0xA0..0xA5
    cycle(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 6; i++) pix(8'hA0 + 8'(i));
    cycle(0, 0, 8'h00, 1, 0, 0);
    check("short_flush", dut_mem[1], 32'h0000A5A4);
    check("short_len", frame_len, 6);
    check("short_err", err_flags, 4'h4);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // Overflow: 17 pixels
    writes_seen = 0;
    cycle(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 17; i++) pix(8'h30 + 8'(i));
    cycle(0, 0, 8'h00, 1, 0, 0);
    check("ovf_writes", writes_seen, 4);
    check("ovf_err", err_flags, 4'h2);
    check("ovf_len", frame_len, 16);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // Stray pixel in IDLE, then start while DONE
    pix(8'h77);
    check("stray_err", err_flags, 4'h1);
    cycle(0, 0, 8'h00, 0, 0, 1);
    cycle(1, 0, 8'h00, 0, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 0);
    cycle(1, 0, 8'h00, 0, 0, 0);
    check("restart_state", dbg_state, S_DONE);
    check("restart_bit", err_flags[3], 1'b1);
    cycle(0, 0, 8'h00, 0, 0, 1);
    check("clear_err", err_flags, 4'h0);
    cycle(0, 0, 8'h00, 0, 1, 0);

    // Coincident pulses
    cycle(1, 1, 8'h55, 0, 0, 0);
    for (int i = 0; i < 14; i++) pix(8'h60 + 8'(i));
    cycle(0, 1, 8'hEE, 1, 0, 0);
    check("coin_lane0", dut_mem[0][7:0], 8'h55);
    check("coin_len", frame_len, 16);
    check("coin_last", dut_mem[3][31:24], 8'hEE);
    check("coin_err", err_flags, 4'h0);
    cycle(1, 0, 8'h00, 0, 1, 0);
    check("ackstart_state", dbg_state, S_RECV);
    check("ackstart_err", err_flags, 4'h0);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 5; i++) pix(8'h90 + 8'(i));
    do_reset();
    cycle(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) pix(8'(i) ^ 8'hC3);
    cycle(0, 0, 8'h00, 1, 0, 0);
    check("post_rst_count", frame_count, 1);
    check("post_rst_err", err_flags, 4'h0);
    cycle(0, 0, 8'h00, 0, 1, 0);

    // Random pulse traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
    end
    idle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
